// File: rtl/us_pkg.sv
// rtl/us_pkg.sv - shared constants and state encoding for the ultrasonic scan scheduler
package us_pkg;
  localparam int DIST_W            = 16;
  localparam int NUM_SENSORS_DEF   = 9;
  localparam int TIMEOUT_TICKS_DEF = 4000;
  localparam int GAP_TICKS_DEF     = 6000;
  localparam int IDX_W             = 4;
  localparam int CNT_W             = 16;

  localparam logic [DIST_W-1:0] DIST_TIMEOUT_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_MEASURE,
    ST_GAP
  } state_t;
endpackage

// File: rtl/us_scan_scheduler_if.sv
// rtl/us_scan_scheduler_if.sv - measure request / result bus between scheduler and hcsr04 channels
interface us_scan_scheduler_if #(
  parameter int NUM_SENSORS = us_pkg::NUM_SENSORS_DEF,
  parameter int DIST_W      = us_pkg::DIST_W
);
  logic [NUM_SENSORS-1:0]        us_measure;
  logic [NUM_SENSORS*DIST_W-1:0] us_ticks;
  logic [NUM_SENSORS-1:0]        us_valid;

  modport master (output us_measure, input us_ticks, input us_valid);
  modport slave  (input us_measure, output us_ticks, output us_valid);
endinterface

// File: rtl/us_next_sel.sv
// rtl/us_next_sel.sv - lowest masked sensor index at or above a start index
module us_next_sel
  import us_pkg::*;
#(
  parameter int NUM_SENSORS = NUM_SENSORS_DEF
) (
  input  logic [NUM_SENSORS-1:0] mask,
  input  logic [IDX_W-1:0]       start,
  output logic [IDX_W-1:0]       idx,
  output logic                   found
);
  // Scanning downward lets the lowest qualifying index overwrite the others.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) >= start)) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/us_scan_scheduler.sv
// rtl/us_scan_scheduler.sv - one-at-a-time HC-SR04 scan with timeout, ring-down gap and latched frame
module us_scan_scheduler #(
  parameter int NUM_SENSORS   = us_pkg::NUM_SENSORS_DEF,
  parameter int DIST_W        = us_pkg::DIST_W,
  parameter int TIMEOUT_TICKS = us_pkg::TIMEOUT_TICKS_DEF,
  parameter int GAP_TICKS     = us_pkg::GAP_TICKS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_en,
  input  logic                          enable,
  input  logic [NUM_SENSORS-1:0]        sensor_mask,
  us_scan_scheduler_if.master           us_bus,
  output logic [NUM_SENSORS*DIST_W-1:0] dist_frame,
  output logic [NUM_SENSORS-1:0]        dist_ok,
  output logic [us_pkg::IDX_W-1:0]      cur_idx,
  output logic                          busy,
  output logic                          frame_done
);
  import us_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(GAP_TICKS);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  search_start, start_nxt;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_found;
  logic [CNT_W-1:0]  cnt;
  logic              valid_prev, valid_cur, valid_rise;
  logic              sel_load, cnt_clr, cnt_run, done_ok, done_to, pass_end;

  us_next_sel #(
    .NUM_SENSORS (NUM_SENSORS)
  ) u_next_sel (
    .mask  (sensor_mask),
    .start (search_start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign valid_cur  = us_bus.us_valid[cur_idx];
  assign valid_rise = valid_cur & ~valid_prev;
  assign cnt_run    = (state == ST_MEASURE) || (state == ST_GAP);
  assign busy       = (state != ST_IDLE);
  assign us_bus.us_measure = (state == ST_MEASURE) ? (NUM_SENSORS'(1) << cur_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = search_start;
    sel_load  = 1'b0;
    cnt_clr   = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    pass_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable && (sensor_mask != '0)) begin
          state_nxt = ST_SELECT;
          start_nxt = '0;
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          sel_load  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_MEASURE;
        end else begin
          pass_end  = 1'b1;
          start_nxt = '0;
          state_nxt = enable ? ST_SELECT : ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (valid_rise) begin
          done_ok   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_GAP;
        end else if (cnt >= TIMEOUT_LIM) begin
          done_to   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt >= GAP_LIM) begin
          start_nxt = cur_idx + IDX_W'(1);
          state_nxt = ST_SELECT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The edge detector is preloaded with the selected channel's current level,
  // so a valid still high from that channel's previous result is not a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      search_start <= '0;
      cur_idx      <= '0;
      cnt          <= '0;
      valid_prev   <= 1'b0;
      frame_done   <= 1'b0;
      dist_frame   <= '0;
      dist_ok      <= '0;
    end else begin
      search_start <= start_nxt;
      frame_done   <= pass_end;
      if (sel_load) begin
        cur_idx    <= sel_idx;
        valid_prev <= us_bus.us_valid[sel_idx];
      end else if (state == ST_MEASURE) begin
        valid_prev <= valid_cur;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_run && tick_en && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (cur_idx == IDX_W'(i)) begin
          if (done_ok) begin
            dist_frame[i*DIST_W +: DIST_W] <= us_bus.us_ticks[i*DIST_W +: DIST_W];
            dist_ok[i]                     <= 1'b1;
          end else if (done_to) begin
            dist_frame[i*DIST_W +: DIST_W] <= DIST_W'(DIST_TIMEOUT_VAL);
            dist_ok[i]                     <= 1'b0;
          end
        end
      end
    end
  end
endmodule
